// File: rtl/io_intr_port.sv
// Memory-mapped I/O port with a CTRL word that queues fast/normal interrupt requests.
// Define IO_INTR_PEND_COUNT_EN for saturating pending counters instead of 1-bit flags.
module io_intr_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 4
) (
  input  logic              Clk,
  input  logic              Reset_,
  input  logic [ADDR_W-1:0] Addr,
  inout  wire  [DATA_W-1:0] Data,
  input  logic              CS_,
  input  logic              RD_,
  input  logic              WR_,
  input  logic              Enable,
  input  logic              int_ack,
  output logic              fintr_check,
  output logic              intr_check
);

`ifdef IO_INTR_PEND_COUNT_EN
  localparam int PW = CNT_W;
`else
  localparam int PW = 1;
`endif

  localparam logic [ADDR_W-1:0] CTRL_ADDR = {ADDR_W{1'b1}};
  localparam logic [PW-1:0]     PMAX      = {PW{1'b1}};
  localparam int                SW        = 2 + 2 * CNT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ_F = 2'd1,
    REQ_N = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state;
  logic        ack_q;
  logic [PW-1:0] fast_cnt;
  logic [PW-1:0] norm_cnt;

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  logic acc;
  logic rd_en;
  logic wr_en;
  logic is_ctrl;
  logic ctrl_wr;
  logic inc_f;
  logic inc_n;
  logic clr;
  logic ack_rise;
  logic dec_f;
  logic dec_n;
  logic [SW-1:0]     status;
  logic [DATA_W-1:0] rd_data;

  assign acc      = Enable & ~CS_;
  assign rd_en    = acc & ~RD_;
  assign wr_en    = acc & ~WR_;
  assign is_ctrl  = (Addr == CTRL_ADDR);
  assign ctrl_wr  = wr_en & is_ctrl;
  assign inc_f    = ctrl_wr & Data[0];
  assign inc_n    = ctrl_wr & Data[1];
  assign clr      = ctrl_wr & Data[2];
  assign ack_rise = int_ack & ~ack_q;
  assign dec_f    = ack_rise & (state == REQ_F);
  assign dec_n    = ack_rise & (state == REQ_N);

  assign status  = {state, CNT_W'(norm_cnt), CNT_W'(fast_cnt)};
  assign rd_data = is_ctrl ? DATA_W'(status) : mem[Addr];
  assign Data    = rd_en ? rd_data : {DATA_W{1'bz}};

  // Clear wins; a same-edge inc and dec cancel out.
  function automatic logic [PW-1:0] cnt_next(
    input logic [PW-1:0] c,
    input logic          inc,
    input logic          dec,
    input logic          cl
  );
    logic [PW-1:0] n;
    n = c;
    if (cl) begin
      n = '0;
    end else if (inc && !dec) begin
      n = (c == PMAX) ? c : c + PW'(1);
    end else if (dec && !inc) begin
      n = c - PW'(1);
    end
    return n;
  endfunction

  always_ff @(posedge Clk) begin
    if (wr_en && !is_ctrl) begin
      mem[Addr] <= Data;
    end
  end

  always_ff @(posedge Clk or negedge Reset_) begin
    if (!Reset_) begin
      state       <= IDLE;
      ack_q       <= 1'b0;
      fast_cnt    <= '0;
      norm_cnt    <= '0;
      fintr_check <= 1'b0;
      intr_check  <= 1'b0;
    end else begin
      ack_q    <= int_ack;
      fast_cnt <= cnt_next(fast_cnt, inc_f, dec_f, clr);
      norm_cnt <= cnt_next(norm_cnt, inc_n, dec_n, clr);
      unique case (state)
        IDLE: begin
          if (fast_cnt != '0) begin
            state       <= REQ_F;
            fintr_check <= 1'b1;
          end else if (norm_cnt != '0) begin
            state      <= REQ_N;
            intr_check <= 1'b1;
          end
        end
        REQ_F: begin
          if (clr || ack_rise) begin
            state       <= DROP;
            fintr_check <= 1'b0;
          end
        end
        REQ_N: begin
          if (clr || ack_rise) begin
            state      <= DROP;
            intr_check <= 1'b0;
          end
        end
        DROP: begin
          if (!int_ack) begin
            state <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          fintr_check <= 1'b0;
          intr_check  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_intr_port.sv
// Directed bench for io_intr_port: bus access, interrupt handshakes, reset.
// Expected values are queued before each stimulus and popped at each check.
module tb_io_intr_port;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam logic [AW-1:0] CTRL = {AW{1'b1}};

  logic          Clk;
  logic          Reset_;
  logic [AW-1:0] Addr;
  wire  [DW-1:0] Data;
  logic          CS_;
  logic          RD_;
  logic          WR_;
  logic          Enable;
  logic          int_ack;
  logic          fintr_check;
  logic          intr_check;

  logic          drv_en;
  logic [DW-1:0] drv_val;

  int n_cmp;
  int n_err;
  logic [DW-1:0] sb [$];

  assign Data = drv_en ? drv_val : {DW{1'bz}};

  io_intr_port #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(4)) dut (
    .Clk        (Clk),
    .Reset_     (Reset_),
    .Addr       (Addr),
    .Data       (Data),
    .CS_        (CS_),
    .RD_        (RD_),
    .WR_        (WR_),
    .Enable     (Enable),
    .int_ack    (int_ack),
    .fintr_check(fintr_check),
    .intr_check (intr_check)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(negedge Clk) begin
    if (Reset_) begin
      n_cmp++;
      assert ((fintr_check & intr_check) === 1'b0) else begin
        n_err++;
        $error("FAIL both_req: observed %b%b expected not both", fintr_check, intr_check);
      end
    end
  end

  task automatic expect_v(input logic [DW-1:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs);
    logic [DW-1:0] exp;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %h expected <empty scoreboard>", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic en);
    Enable  = en;
    Addr    = a;
    drv_val = d;
    drv_en  = 1'b1;
    CS_     = 1'b0;
    WR_     = 1'b0;
    cycle();
    CS_     = 1'b1;
    WR_     = 1'b1;
    drv_en  = 1'b0;
    Enable  = 1'b1;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
    Enable = 1'b1;
    Addr   = a;
    CS_    = 1'b0;
    RD_    = 1'b0;
    #1;
    d      = Data;
    RD_    = 1'b1;
    CS_    = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] e);
    logic [DW-1:0] d;
    expect_v(e);
    rd(a, d);
    chk(tag, d);
  endtask

  task automatic out_chk(input string tag, input logic f, input logic n);
    expect_v(DW'({f, n}));
    chk(tag, DW'({fintr_check, intr_check}));
  endtask

  initial begin
    logic [DW-1:0] d;
    int            hs;
    int            exp_hs;
    logic [DW-1:0] exp_st;
    n_cmp   = 0;
    n_err   = 0;
    Reset_  = 1'b0;
    Addr    = '0;
    CS_     = 1'b1;
    RD_     = 1'b1;
    WR_     = 1'b1;
    Enable  = 1'b1;
    int_ack = 1'b0;
    drv_en  = 1'b0;
    drv_val = '0;

    #12;
    out_chk("reset_out", 1'b0, 1'b0);
    Reset_ = 1'b1;
    cycle();
    rd_chk("reset_status", CTRL, 32'h0);

    wr(10'd5, 32'hDEADBEEF, 1'b1);
    rd_chk("mem5", 10'd5, 32'hDEADBEEF);
    wr(10'd0, 32'h0000_0001, 1'b1);
    wr(CTRL - 10'd1, 32'hA5A5_5A5A, 1'b1);
    rd_chk("mem0", 10'd0, 32'h0000_0001);
    rd_chk("mem_top", CTRL - 10'd1, 32'hA5A5_5A5A);

    Addr = 10'd5;
    CS_  = 1'b1;
    RD_  = 1'b0;
    #1;
    n_cmp++;
    assert (Data === 32'hzzzzzzzz) else begin
      n_err++;
      $error("FAIL cs_hiz: observed %h expected zzzzzzzz", Data);
    end
    RD_ = 1'b1;

    wr(10'd5, 32'h1234_5678, 1'b0);
    rd_chk("en0_drop", 10'd5, 32'hDEADBEEF);
    wr(CTRL, 32'h1, 1'b0);
    cycle();
    out_chk("en0_notrig", 1'b0, 1'b0);

    wr(CTRL, 32'h1, 1'b1);
    out_chk("fast_edgeN", 1'b0, 1'b0);
    cycle();
    out_chk("fast_edgeN1", 1'b1, 1'b0);
    rd_chk("fast_status", CTRL, 32'h101);
    int_ack = 1'b1;
    cycle();
    out_chk("fast_ack", 1'b0, 1'b0);
    rd_chk("fast_drop_st", CTRL, 32'h300);
    int_ack = 1'b0;
    cycle();
    rd_chk("fast_idle_st", CTRL, 32'h0);

    wr(CTRL, 32'h3, 1'b1);
    cycle();
    out_chk("both_fast", 1'b1, 1'b0);
    rd_chk("both_st", CTRL, 32'h111);
    int_ack = 1'b1;
    cycle();
    out_chk("both_ackf", 1'b0, 1'b0);
    int_ack = 1'b0;
    cycle();
    out_chk("both_idle", 1'b0, 1'b0);
    cycle();
    out_chk("both_norm", 1'b0, 1'b1);
    rd_chk("norm_st", CTRL, 32'h210);
    int_ack = 1'b1;
    cycle();
    out_chk("both_ackn", 1'b0, 1'b0);
    int_ack = 1'b0;
    cycle();
    cycle();
    rd_chk("both_done", CTRL, 32'h0);

`ifdef IO_INTR_PEND_COUNT_EN
    exp_hs = 15;
    exp_st = 32'h2F0;
`else
    exp_hs = 1;
    exp_st = 32'h210;
`endif
    for (int i = 0; i < 20; i++) begin
      wr(CTRL, 32'h2, 1'b1);
    end
    rd_chk("sat_status", CTRL, exp_st);
    hs = 0;
    while (intr_check && hs < 40) begin
      int_ack = 1'b1;
      cycle();
      int_ack = 1'b0;
      cycle();
      cycle();
      hs++;
    end
    expect_v(DW'(exp_hs));
    chk("handshakes", DW'(hs));
    rd_chk("sat_done", CTRL, 32'h0);

    wr(CTRL, 32'h1, 1'b1);
    cycle();
    out_chk("same_req", 1'b1, 1'b0);
    int_ack = 1'b1;
    wr(CTRL, 32'h1, 1'b1);
    out_chk("same_drop", 1'b0, 1'b0);
    rd_chk("same_status", CTRL, 32'h301);
    int_ack = 1'b0;
    cycle();
    cycle();
    out_chk("same_rereq", 1'b1, 1'b0);
    wr(CTRL, 32'h7, 1'b1);
    out_chk("clr_drop", 1'b0, 1'b0);
    rd_chk("clr_status", CTRL, 32'h300);
    cycle();
    cycle();
    out_chk("clr_stays", 1'b0, 1'b0);

    wr(CTRL, 32'h1, 1'b1);
    cycle();
    out_chk("rst_pre", 1'b1, 1'b0);
    #2;
    Reset_ = 1'b0;
    #1;
    out_chk("rst_async", 1'b0, 1'b0);
    #1;
    Reset_ = 1'b1;
    rd_chk("rst_status", CTRL, 32'h0);
    cycle();
    out_chk("rst_after", 1'b0, 1'b0);
    rd_chk("rst_mem", 10'd5, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/io_intr_port.md
IO_INTR_PORT -- requirements
Module: io_intr_port

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 32, data width.
- ADDR_W, 10, address width; depth is 2^ADDR_W words.
- CNT_W, 4, pending-counter width.
- Legal only when DATA_W >= 2*CNT_W+2.

REQ-002 Ports SHALL be:
- Clk  in  1  single clock; all state changes on posedge.
- Reset_  in  1  asynchronous, active-low reset.
- Addr  in  ADDR_W  word address.
- Data  inout  DATA_W  bidirectional data bus.
- CS_  in  1  chip select, active low.
- RD_  in  1  read strobe, active low.
- WR_  in  1  write strobe, active low.
- Enable  in  1  block enable; when low, no access and no trigger.
- int_ack  in  1  interrupt acknowledge from the CPU.
- fintr_check  out  1  fast interrupt request, registered.
- intr_check  out  1  normal interrupt request, registered.

Function
REQ-003 CTRL_ADDR SHALL be 2^ADDR_W-1; all lower addresses SHALL be memory words.

REQ-004 Data SHALL be driven combinationally only when Enable=1, CS_=0 and RD_=0, otherwise high-Z.
- Addr!=CTRL_ADDR: drive mem[Addr].
- Addr==CTRL_ADDR: drive STATUS.

REQ-005 STATUS SHALL be zero-extended {state[1:0], norm_cnt[CNT_W-1:0], fast_cnt[CNT_W-1:0]}, with fast_cnt in the LSBs.

REQ-006 A write SHALL occur on posedge Clk when Enable=1, CS_=0 and WR_=0.
- Addr!=CTRL_ADDR: mem[Addr] <= Data.
- Addr==CTRL_ADDR: CTRL command, no memory write.

REQ-007 CTRL command bits SHALL be:
- bit0: increment fast_cnt.
- bit1: increment norm_cnt.
- bit2: clear both counters.
- Other bits are ignored.

REQ-008 Counter arithmetic SHALL be:
- Counters saturate at 2^CNT_W-1 and never wrap.
- A decrement at 0 is impossible by construction.

REQ-009 Bit2 SHALL override bits 0/1 and any same-cycle decrement; both counters are 0 after that edge.

REQ-010 int_ack SHALL be registered into ack_q each edge; ack_rise = int_ack & ~ack_q, evaluated at the edge.

REQ-011 The FSM SHALL have states IDLE=0, REQ_F=1, REQ_N=2, DROP=3.

REQ-012 From IDLE, the FSM SHALL go to REQ_F if fast_cnt!=0, else to REQ_N if norm_cnt!=0, else stay in IDLE; fast has priority.

REQ-013 fintr_check SHALL be 1 exactly while the state is REQ_F, and intr_check SHALL be 1 exactly while the state is REQ_N; both are registered and never high together.

REQ-014 Request latency: a trigger write at edge N into an idle block SHALL raise the request output at edge N+1.

REQ-015 In REQ_F or REQ_N, an ack_rise SHALL:
- decrement the matching counter,
- go to DROP,
- deassert the output at that same edge.

REQ-016 In DROP, the FSM SHALL return to IDLE at the first edge with int_ack=0; the next request asserts no earlier than one edge later.

REQ-017 ack_rise in IDLE or DROP SHALL be ignored.

REQ-018 A same-edge increment and decrement of one counter SHALL leave the counter unchanged.

REQ-019 When bit2 clears the counters while in REQ_F or REQ_N, the FSM SHALL go to DROP and deassert the request.

REQ-020 Enable=0 SHALL block only bus accesses; the FSM and handshake continue.

Reset
REQ-021 Reset_=0 SHALL asynchronously force:
- fintr_check=0, intr_check=0,
- fast_cnt=0, norm_cnt=0,
- state=IDLE, ack_q=0.

REQ-022 Memory contents SHALL NOT be reset.

REQ-023 Reset mid-request SHALL drop the request output immediately, without waiting for a Clk edge.

REQ-024 After deassertion, the first state change SHALL occur on the next posedge Clk.

Configuration
REQ-025 With macro IO_INTR_PEND_COUNT_EN defined, fast_cnt and norm_cnt SHALL be CNT_W-bit saturating counters as above.

REQ-026 Without IO_INTR_PEND_COUNT_EN:
- Each counter SHALL be a 1-bit pending flag.
- Repeated triggers collapse into one request.
- The flag sits in bit 0 of its STATUS field; the remaining field bits read 0.
- All other behaviour is unchanged.

Verification
REQ-027 Write 0xDEADBEEF to Addr 5, then read Addr 5 -> Data=0xDEADBEEF; with CS_=1 -> Data=Z; with Enable=0 -> write dropped.

REQ-028 CTRL write 0x1 at edge N -> fintr_check=1 at N+1; int_ack pulse -> fintr_check=0 at the ack_rise edge; STATUS fast_cnt=0.

REQ-029 CTRL write 0x3 -> fintr_check serviced first, then intr_check after int_ack returns low; never both high.

REQ-030 Write 0x2 twenty times with count macro defined -> norm_cnt=15 and exactly 15 intr_check handshakes; without the macro -> norm_cnt=1 and one handshake.

REQ-031 Trigger 0x1 on the same edge as ack_rise for a pending fast request -> fast_cnt unchanged; CTRL write 0x7 -> counters 0 and request dropped.

REQ-032 Assert Reset_ low between edges while fintr_check=1 -> fintr_check=0 immediately; STATUS reads 0 after release.
